arbitro_banco_latch: RTL and testbench



---
 rtl/arbitro_banco_latch_if.sv | 33 +++
 rtl/arbitro_banco_latch.sv | 94 +++++++++
 tb/tb_arbitro_banco_latch.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_banco_latch_if.sv
// Bus shared by the two write requesters and the bank arbiter: request channels A/B,
// their acks, and the observable bank state.
interface arbitro_banco_latch_if #(
  parameter int N_REG = 4,
  parameter int ANCHO = 4,
  parameter int AW    = 2
);
  // Handshake: a requester raises req with dir/dato stable and holds them until it
  // sees its ack (one cycle). By the edge that ends the ack cycle it either drops req
  // or keeps it high with new dir/dato for a further write. Data is captured on the
  // grant edge, so dir/dato are don't-care once the arbiter leaves REPOSO.
  logic                   req_a;
  logic [AW-1:0]          dir_a;
  logic [ANCHO-1:0]       dato_a;
  logic                   req_b;
  logic [AW-1:0]          dir_b;
  logic [ANCHO-1:0]       dato_b;
  logic                   ack_a;
  logic                   ack_b;
  logic                   ocupado;
  logic [N_REG*ANCHO-1:0] salidas;
  logic [7:0]             cuenta;

  modport master (
    output req_a, dir_a, dato_a, req_b, dir_b, dato_b,
    input  ack_a, ack_b, ocupado, salidas, cuenta
  );

  modport slave (
    input  req_a, dir_a, dato_a, req_b, dir_b, dato_b,
    output ack_a, ack_b, ocupado, salidas, cuenta
  );
endinterface

// File: rtl/arbitro_banco_latch.sv
// Round-robin write arbiter for a bank of load-enable registers, with a counter of
// completed in-range writes. At most one write every two cycles.
module arbitro_banco_latch #(
  parameter int N_REG = 4,
  parameter int ANCHO = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arbitro_banco_latch_if.slave bus,
  output logic [1:0]           estado
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CARGA_A = 2'd1,
    CARGA_B = 2'd2
  } estado_t;

  estado_t          state_q, state_d;
  logic             prio_q;
  logic [AW-1:0]    dir_q;
  logic [ANCHO-1:0] dato_q;
  logic [7:0]       cuenta_q;
  logic             carga;
  logic [N_REG-1:0] sel;
  logic [ANCHO-1:0] banco [N_REG];
  logic [N_REG*ANCHO-1:0] salidas_int;

  // prio=0 favours A on a tie, prio=1 favours B.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REPOSO: begin
        if (bus.req_a && (!bus.req_b || !prio_q)) state_d = CARGA_A;
        else if (bus.req_b)                       state_d = CARGA_B;
      end
      CARGA_A: state_d = REPOSO;
      CARGA_B: state_d = REPOSO;
      default: state_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REPOSO;
      prio_q  <= 1'b0;
      dir_q   <= '0;
      dato_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == REPOSO && state_d == CARGA_A) begin
        dir_q  <= bus.dir_a;
        dato_q <= bus.dato_a;
      end else if (state_q == REPOSO && state_d == CARGA_B) begin
        dir_q  <= bus.dir_b;
        dato_q <= bus.dato_b;
      end
      if (state_q == CARGA_A)      prio_q <= 1'b1;
      else if (state_q == CARGA_B) prio_q <= 1'b0;
    end
  end

  assign carga = (state_q == CARGA_A) || (state_q == CARGA_B);

  // An out-of-range held address matches no index, so no cell loads.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REG; i++) begin
      sel[i] = carga && (dir_q == AW'(i));
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_celda
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      banco[g] <= '0;
      else if (sel[g]) banco[g] <= dato_q;
    end
    assign salidas_int[g*ANCHO +: ANCHO] = banco[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cuenta_q <= 8'd0;
    else if (|sel) cuenta_q <= cuenta_q + 8'd1;
  end

  assign bus.ack_a   = (state_q == CARGA_A);
  assign bus.ack_b   = (state_q == CARGA_B);
  assign bus.ocupado = (state_q != REPOSO);
  assign bus.salidas = salidas_int;
  assign bus.cuenta  = cuenta_q;
  assign estado      = state_q;

endmodule

// File: tb/tb_arbitro_banco_latch.sv
// Bench for arbitro_banco_latch: a 4-register instance for the main scenarios and a
// 3-register instance for the out-of-range address case.
module tb_arbitro_banco_latch;
  localparam int ANCHO = 4;
  localparam int AW    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] estado4, estado3;

  arbitro_banco_latch_if #(.N_REG(4), .ANCHO(ANCHO), .AW(AW)) bus4();
  arbitro_banco_latch_if #(.N_REG(3), .ANCHO(ANCHO), .AW(AW)) bus3();

  arbitro_banco_latch #(.N_REG(4), .ANCHO(ANCHO), .AW(AW)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .estado(estado4)
  );
  arbitro_banco_latch #(.N_REG(3), .ANCHO(ANCHO), .AW(AW)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .estado(estado3)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {who(0=A,1=B), dir, dato} in expected grant order.
  logic [AW+ANCHO:0]   exp_q[$];
  logic [AW+ANCHO-1:0] pend_a[$];
  logic [AW+ANCHO-1:0] pend_b[$];
  logic [ANCHO-1:0]    modelo [4];
  logic [7:0]          cuenta_m;

  function automatic logic [4*ANCHO-1:0] modelo_sal();
    logic [4*ANCHO-1:0] v;
    for (int i = 0; i < 4; i++) v[i*ANCHO +: ANCHO] = modelo[i];
    return v;
  endfunction

  // Driver tasks
  task automatic set_idle();
    bus4.req_a = 1'b0; bus4.dir_a = '0; bus4.dato_a = '0;
    bus4.req_b = 1'b0; bus4.dir_b = '0; bus4.dato_b = '0;
    bus3.req_a = 1'b0; bus3.dir_a = '0; bus3.dato_a = '0;
    bus3.req_b = 1'b0; bus3.dir_b = '0; bus3.dato_b = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus4.req_a = 1'($urandom_range(0, 1)); bus4.dir_a = AW'($urandom_range(0, 3));
    bus4.dato_a = ANCHO'($urandom_range(0, 15));
    bus4.req_b = 1'($urandom_range(0, 1)); bus4.dir_b = AW'($urandom_range(0, 3));
    bus4.dato_b = ANCHO'($urandom_range(0, 15));
    bus3.req_a = 1'($urandom_range(0, 1)); bus3.req_b = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) modelo[i] = '0;
    cuenta_m = 8'd0;
    exp_q.delete(); pend_a.delete(); pend_b.delete();
  endtask

  task automatic drive_reqs();
    bus4.req_a = (pend_a.size() > 0);
    if (pend_a.size() > 0) {bus4.dir_a, bus4.dato_a} = pend_a[0];
    bus4.req_b = (pend_b.size() > 0);
    if (pend_b.size() > 0) {bus4.dir_b, bus4.dato_b} = pend_b[0];
  endtask

  // Runs the pending requests on bus4, scoring each grant against exp_q.
  task automatic servir(input int max_ciclos, output int primero, output int ultimo);
    int ciclo = 0;
    bit pend_chk = 1'b0;
    logic [AW+ANCHO:0] obs, esp;
    primero = -1;
    ultimo  = -10;
    drive_reqs();
    while ((pend_a.size() > 0 || pend_b.size() > 0 || pend_chk) && ciclo < max_ciclos) begin
      @(negedge clk);
      ciclo++;
      if (pend_chk) begin
        pend_chk = 1'b0;
        checks++;
        if (bus4.salidas !== modelo_sal()) begin
          errors++;
          $display("FAIL salidas_after_write got %h expected %h", bus4.salidas, modelo_sal());
        end
        checks++;
        if (bus4.cuenta !== cuenta_m) begin
          errors++;
          $display("FAIL cuenta_after_write got %0d expected %0d", bus4.cuenta, cuenta_m);
        end
      end
      checks++;
      if (bus4.ack_a === 1'b1 && bus4.ack_b === 1'b1) begin
        errors++;
        $display("FAIL double_ack got ack_a=1 ack_b=1 expected at most one");
      end
      if (bus4.ack_a === 1'b1 || bus4.ack_b === 1'b1) begin
        checks++;
        if (ciclo - ultimo < 2) begin
          errors++;
          $display("FAIL ack_spacing got gap %0d expected >=2", ciclo - ultimo);
        end
        if (primero < 0) primero = ciclo;
        ultimo = ciclo;
        if (bus4.ack_b === 1'b1) obs = (pend_b.size() > 0) ? {1'b1, pend_b[0]} : {1'b1, 6'h3f};
        else                     obs = (pend_a.size() > 0) ? {1'b0, pend_a[0]} : {1'b0, 6'h3f};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant got %h expected none", obs);
        end else begin
          esp = exp_q.pop_front();
          if (obs !== esp) begin
            errors++;
            $display("FAIL grant_order got %h expected %h", obs, esp);
          end
          modelo[esp[AW+ANCHO-1:ANCHO]] = esp[ANCHO-1:0];
          cuenta_m = cuenta_m + 8'd1;
        end
        if (bus4.ack_b === 1'b1) begin
          if (pend_b.size() > 0) void'(pend_b.pop_front());
        end else begin
          if (pend_a.size() > 0) void'(pend_a.pop_front());
        end
        pend_chk = 1'b1;
        drive_reqs();
      end
    end
    checks++;
    if (pend_a.size() > 0 || pend_b.size() > 0 || exp_q.size() > 0) begin
      errors++;
      $display("FAIL servir_timeout got pending %0d/%0d exp %0d expected 0/0/0",
               pend_a.size(), pend_b.size(), exp_q.size());
    end
    set_idle();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (bus4.salidas !== 16'h0 || bus4.cuenta !== 8'd0 || bus4.ack_a !== 1'b0 ||
        bus4.ack_b !== 1'b0 || bus4.ocupado !== 1'b0 || estado4 !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got sal=%h cnt=%0d acks=%b%b ocu=%b st=%0d expected all 0",
               bus4.salidas, bus4.cuenta, bus4.ack_a, bus4.ack_b, bus4.ocupado, estado4);
    end
    // Interrupt a write to register 1 in its CARGA_A cycle.
    bus4.req_a = 1'b1; bus4.dir_a = 2'd1; bus4.dato_a = 4'h7;
    @(negedge clk);
    checks++;
    if (bus4.ack_a !== 1'b1 || bus4.ocupado !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_carga got ack_a=%b ocupado=%b expected 1 1", bus4.ack_a, bus4.ocupado);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.ack_a !== 1'b0 || bus4.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_carga got ack_a=%b ocupado=%b expected 0 0", bus4.ack_a, bus4.ocupado);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.salidas !== 16'h0 || bus4.cuenta !== 8'd0) begin
      errors++;
      $display("FAIL reset_lost_write got sal=%h cnt=%0d expected 0000 0", bus4.salidas, bus4.cuenta);
    end
    for (int i = 0; i < 4; i++) modelo[i] = '0;
    cuenta_m = 8'd0;
  endtask

  task automatic test_single();
    int p, u;
    pend_a.push_back({2'd2, 4'hA});
    exp_q.push_back({1'b0, 2'd2, 4'hA});
    servir(10, p, u);
    checks++;
    if (bus4.salidas !== 16'h0A00 || bus4.cuenta !== 8'd1) begin
      errors++;
      $display("FAIL single_write got sal=%h cnt=%0d expected 0a00 1", bus4.salidas, bus4.cuenta);
    end
    checks++;
    if (bus4.ack_a !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_len got ack_a=%b expected 0", bus4.ack_a);
    end
  endtask

  task automatic test_contention();
    int p, u;
    apply_reset();
    pend_a.push_back({2'd0, 4'h3});
    pend_b.push_back({2'd1, 4'h5});
    exp_q.push_back({1'b0, 2'd0, 4'h3});
    exp_q.push_back({1'b1, 2'd1, 4'h5});
    servir(10, p, u);
    checks++;
    if (bus4.salidas[7:0] !== 8'h53) begin
      errors++;
      $display("FAIL contention_data got %h expected 53", bus4.salidas[7:0]);
    end
  endtask

  task automatic test_fairness();
    int p, u;
    logic [AW+ANCHO-1:0] e;
    // Previous grant went to B, so A is favoured first.
    for (int i = 0; i < 4; i++) begin
      e = {AW'($urandom_range(0, 3)), ANCHO'($urandom_range(0, 15))};
      pend_a.push_back(e);
      exp_q.push_back({1'b0, e});
      e = {AW'($urandom_range(0, 3)), ANCHO'($urandom_range(0, 15))};
      pend_b.push_back(e);
      exp_q.push_back({1'b1, e});
    end
    servir(40, p, u);
    checks++;
    if (u - p !== 14) begin
      errors++;
      $display("FAIL fairness_rate got span %0d expected 14", u - p);
    end
  endtask

  task automatic test_overwrite();
    int p, u;
    pend_a.push_back({2'd3, 4'hF});
    pend_b.push_back({2'd3, 4'h1});
    exp_q.push_back({1'b0, 2'd3, 4'hF});
    exp_q.push_back({1'b1, 2'd3, 4'h1});
    servir(10, p, u);
    repeat (20) @(negedge clk);
    checks++;
    if (bus4.salidas !== modelo_sal() || bus4.salidas[15:12] !== 4'h1) begin
      errors++;
      $display("FAIL overwrite_hold got %h expected %h", bus4.salidas, modelo_sal());
    end
  endtask

  task automatic test_wrap();
    int p, u;
    logic [AW+ANCHO-1:0] e;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      e = {AW'($urandom_range(0, 3)), ANCHO'($urandom_range(0, 15))};
      pend_a.push_back(e);
      exp_q.push_back({1'b0, e});
    end
    servir(700, p, u);
    checks++;
    if (bus4.cuenta !== 8'd0) begin
      errors++;
      $display("FAIL counter_wrap got %0d expected 0", bus4.cuenta);
    end
  endtask

  task automatic wait_ack_b3(input string nombre);
    int n = 0;
    while (bus3.ack_b !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus3.ack_b !== 1'b1) begin
      errors++;
      $display("FAIL %s got no ack_b within 10 cycles expected ack", nombre);
    end
    bus3.req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    apply_reset();
    bus3.req_b = 1'b1; bus3.dir_b = 2'd2; bus3.dato_b = 4'h9;
    wait_ack_b3("oor_ack_inrange");
    checks++;
    if (bus3.salidas !== 12'h900 || bus3.cuenta !== 8'd1) begin
      errors++;
      $display("FAIL oor_inrange got sal=%h cnt=%0d expected 900 1", bus3.salidas, bus3.cuenta);
    end
    bus3.req_b = 1'b1; bus3.dir_b = 2'd3; bus3.dato_b = 4'hF;
    wait_ack_b3("oor_ack");
    checks++;
    if (bus3.salidas !== 12'h900 || bus3.cuenta !== 8'd1) begin
      errors++;
      $display("FAIL oor_nowrite got sal=%h cnt=%0d expected 900 1", bus3.salidas, bus3.cuenta);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_overwrite();
    test_wrap();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
